// File: rtl/if_fifo_multi.sv
// Multi-lane fetch-to-decode instruction queue: packs valid fetch lanes contiguously
// into a circular buffer and presents the oldest LANES entries to decode.
module if_fifo_multi #(
  parameter int LANES = 3,
  parameter int DEPTH = 8,
  parameter int PHT_W = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           IF_pinch_off,
  input  logic                           flush_IF_FIFO,
  input  logic [LANES-1:0]               in_valid,
  input  logic [LANES*32-1:0]            in_pc,
  input  logic [LANES*32-1:0]            in_inst,
  input  logic [LANES*32-1:0]            in_pc_unsel,
  input  logic [LANES-1:0]               in_predict_valid,
  input  logic [LANES-1:0]               in_predict,
  input  logic [LANES*PHT_W-1:0]         in_pht_idx,
  input  logic [$clog2(LANES+1)-1:0]     deq_num,
  output logic [LANES-1:0]               out_valid,
  output logic [LANES*32-1:0]            out_pc,
  output logic [LANES*32-1:0]            out_inst,
  output logic [LANES*32-1:0]            out_pc_unsel,
  output logic [LANES-1:0]               out_predict_valid,
  output logic [LANES-1:0]               out_predict,
  output logic [LANES*PHT_W-1:0]         out_pht_idx,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           IF_FIFO_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]      pc_mem       [DEPTH];
  logic [31:0]      inst_mem     [DEPTH];
  logic [31:0]      pc_unsel_mem [DEPTH];
  logic             pred_vld_mem [DEPTH];
  logic             pred_mem     [DEPTH];
  logic [PHT_W-1:0] pht_mem      [DEPTH];

  logic [PTR_W-1:0] head_ptr_reg, head_ptr_next;
  logic [PTR_W-1:0] tail_ptr_reg, tail_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic [PTR_W-1:0] lane_ofs [LANES];
  logic [CNT_W-1:0] enq_num;
  logic [CNT_W-1:0] deq_req;
  logic [CNT_W-1:0] deq_eff;
  logic             accept;

  // Full looks only at the pre-edge occupancy; same-cycle dequeue never makes room.
  assign IF_FIFO_full = (CNT_W'(DEPTH) - count_reg) < CNT_W'(LANES);
  assign count        = count_reg;
  assign accept       = (|in_valid) & ~IF_pinch_off & ~IF_FIFO_full & ~flush_IF_FIFO;

  // Each valid lane lands at tail + (number of valid lanes below it).
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_ofs
      logic [PTR_W-1:0] ofs;
      always_comb begin
        ofs = '0;
        for (int j = 0; j < gi; j++) begin
          ofs = ofs + PTR_W'(in_valid[j]);
        end
        lane_ofs[gi] = ofs;
      end
    end
  endgenerate

  always_comb begin
    enq_num = '0;
    for (int j = 0; j < LANES; j++) begin
      enq_num = enq_num + CNT_W'(in_valid[j]);
    end
  end

  // Decode may ask for more than is present; clamp to the occupancy.
  assign deq_req = CNT_W'(deq_num);
  assign deq_eff = (deq_req > count_reg) ? count_reg : deq_req;

  always_comb begin
    head_ptr_next = head_ptr_reg + PTR_W'(deq_eff);
    tail_ptr_next = accept ? (tail_ptr_reg + PTR_W'(enq_num)) : tail_ptr_reg;
    count_next    = count_reg + (accept ? enq_num : '0) - deq_eff;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else if (flush_IF_FIFO) begin
      head_ptr_reg <= '0;
      tail_ptr_reg <= '0;
      count_reg    <= '0;
    end else begin
      head_ptr_reg <= head_ptr_next;
      tail_ptr_reg <= tail_ptr_next;
      count_reg    <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        pc_mem[e]       <= '0;
        inst_mem[e]     <= '0;
        pc_unsel_mem[e] <= '0;
        pred_vld_mem[e] <= 1'b0;
        pred_mem[e]     <= 1'b0;
        pht_mem[e]      <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_valid[i]) begin
          pc_mem[tail_ptr_reg + lane_ofs[i]]       <= in_pc[32*i +: 32];
          inst_mem[tail_ptr_reg + lane_ofs[i]]     <= in_inst[32*i +: 32];
          pc_unsel_mem[tail_ptr_reg + lane_ofs[i]] <= in_pc_unsel[32*i +: 32];
          pred_vld_mem[tail_ptr_reg + lane_ofs[i]] <= in_predict_valid[i];
          pred_mem[tail_ptr_reg + lane_ofs[i]]     <= in_predict[i];
          pht_mem[tail_ptr_reg + lane_ofs[i]]      <= in_pht_idx[PHT_W*i +: PHT_W];
        end
      end
    end
  end

  // Output lane i shows entry head+i; the pointer add wraps modulo DEPTH.
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_out
      logic [PTR_W-1:0] rd_idx;
      assign rd_idx                            = head_ptr_reg + PTR_W'(gi);
      assign out_valid[gi]                     = CNT_W'(gi) < count_reg;
      assign out_pc[32*gi +: 32]               = pc_mem[rd_idx];
      assign out_inst[32*gi +: 32]             = inst_mem[rd_idx];
      assign out_pc_unsel[32*gi +: 32]         = pc_unsel_mem[rd_idx];
      assign out_predict_valid[gi]             = pred_vld_mem[rd_idx];
      assign out_predict[gi]                   = pred_mem[rd_idx];
      assign out_pht_idx[PHT_W*gi +: PHT_W]    = pht_mem[rd_idx];
    end
  endgenerate

endmodule

// File: tb/tb_if_fifo_multi.sv
// Scoreboard bench for if_fifo_multi: directed steps push expected state, a monitor
// compares it after each edge. Side fields are fixed functions of the lane pc.
module tb_if_fifo_multi;

  localparam int LANES = 3;
  localparam int DEPTH = 8;
  localparam int PHT_W = 10;

  logic                   clk, rst, IF_pinch_off, flush_IF_FIFO;
  logic [LANES-1:0]       in_valid, in_predict_valid, in_predict;
  logic [LANES*32-1:0]    in_pc, in_inst, in_pc_unsel;
  logic [LANES*PHT_W-1:0] in_pht_idx;
  logic [1:0]             deq_num;
  logic [LANES-1:0]       out_valid, out_predict_valid, out_predict;
  logic [LANES*32-1:0]    out_pc, out_inst, out_pc_unsel;
  logic [LANES*PHT_W-1:0] out_pht_idx;
  logic [3:0]             count;
  logic                   IF_FIFO_full;

  if_fifo_multi #(.LANES(LANES), .DEPTH(DEPTH), .PHT_W(PHT_W)) dut (
    .clk(clk), .rst(rst), .IF_pinch_off(IF_pinch_off), .flush_IF_FIFO(flush_IF_FIFO),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_pc_unsel(in_pc_unsel),
    .in_predict_valid(in_predict_valid), .in_predict(in_predict), .in_pht_idx(in_pht_idx),
    .deq_num(deq_num), .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_pc_unsel(out_pc_unsel), .out_predict_valid(out_predict_valid),
    .out_predict(out_predict), .out_pht_idx(out_pht_idx), .count(count),
    .IF_FIFO_full(IF_FIFO_full)
  );

  typedef struct {
    int          id;
    logic [3:0]  cnt;
    logic [2:0]  vld;
    logic        full;
    logic [31:0] pc [3];
  } exp_t;

  exp_t exp_q [$];
  int   errors = 0;
  int   checks = 0;
  int   txn_id = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] p);   return ~p;             endfunction
  function automatic logic [31:0] unsel_of(input logic [31:0] p);  return p + 32'h40;     endfunction
  function automatic logic        pv_of(input logic [31:0] p);     return ~p[3];          endfunction
  function automatic logic        pr_of(input logic [31:0] p);     return p[3];           endfunction
  function automatic logic [9:0]  pht_of(input logic [31:0] p);    return p[11:2];        endfunction

  task automatic step(input logic [2:0] v, input logic [31:0] p0, p1, p2,
                      input logic pin, fl, input logic [1:0] dq,
                      input int ecnt, input logic efull,
                      input logic [31:0] e0, e1, e2);
    exp_t e;
    @(negedge clk);
    in_valid         = v;
    in_pc            = {p2, p1, p0};
    in_inst          = {inst_of(p2), inst_of(p1), inst_of(p0)};
    in_pc_unsel      = {unsel_of(p2), unsel_of(p1), unsel_of(p0)};
    in_predict_valid = {pv_of(p2), pv_of(p1), pv_of(p0)};
    in_predict       = {pr_of(p2), pr_of(p1), pr_of(p0)};
    in_pht_idx       = {pht_of(p2), pht_of(p1), pht_of(p0)};
    IF_pinch_off     = pin;
    flush_IF_FIFO    = fl;
    deq_num          = dq;
    e.id    = txn_id++;
    e.cnt   = 4'(ecnt);
    e.vld   = (ecnt >= 3) ? 3'b111 : (ecnt == 2) ? 3'b011 : (ecnt == 1) ? 3'b001 : 3'b000;
    e.full  = efull;
    e.pc[0] = e0;
    e.pc[1] = e1;
    e.pc[2] = e2;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: one expected snapshot per edge following a driven step.
  always @(posedge clk) begin
    exp_t        e;
    logic [31:0] p;
    int          err0;
    #1;
    if (exp_q.size() > 0) begin
      e    = exp_q.pop_front();
      err0 = errors;
      chk($sformatf("t%0d count", e.id), 32'(count), 32'(e.cnt));
      chk($sformatf("t%0d out_valid", e.id), 32'(out_valid), 32'(e.vld));
      chk($sformatf("t%0d full", e.id), 32'(IF_FIFO_full), 32'(e.full));
      for (int i = 0; i < 3; i++) begin
        if (e.vld[i]) begin
          p = e.pc[i];
          chk($sformatf("t%0d pc[%0d]", e.id, i), out_pc[32*i +: 32], p);
          chk($sformatf("t%0d inst[%0d]", e.id, i), out_inst[32*i +: 32], inst_of(p));
          chk($sformatf("t%0d pc_unsel[%0d]", e.id, i), out_pc_unsel[32*i +: 32], unsel_of(p));
          chk($sformatf("t%0d pred_vld[%0d]", e.id, i), 32'(out_predict_valid[i]), 32'(pv_of(p)));
          chk($sformatf("t%0d pred[%0d]", e.id, i), 32'(out_predict[i]), 32'(pr_of(p)));
          chk($sformatf("t%0d pht[%0d]", e.id, i), 32'(out_pht_idx[PHT_W*i +: PHT_W]), 32'(pht_of(p)));
        end
      end
      $display("txn %0d count=%0d out_valid=%b full=%b new_errors=%0d",
               e.id, count, out_valid, IF_FIFO_full, errors - err0);
    end
  end

  initial begin
    rst = 1'b0;
    IF_pinch_off = 1'b0; flush_IF_FIFO = 1'b0; deq_num = '0;
    in_valid = '0; in_pc = '0; in_inst = '0; in_pc_unsel = '0;
    in_predict_valid = '0; in_predict = '0; in_pht_idx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("reset count", 32'(count), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset full", 32'(IF_FIFO_full), 32'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("reset pc[%0d]", i), out_pc[32*i +: 32], 32'd0);

    //    valid   p0            p1            p2        pin fl dq cnt full  e0            e1            e2
    step(3'b111, 32'h1C000000, 32'h1C000004, 32'h1C000008, 0, 0, 0, 3, 0, 32'h1C000000, 32'h1C000004, 32'h1C000008);
    step(3'b000, 32'h0,   32'h0,    32'h0,   0, 0, 3, 0, 0, 32'h0,   32'h0,   32'h0);
    step(3'b101, 32'h100, 32'hDEAD, 32'h108, 0, 0, 0, 2, 0, 32'h100, 32'h108, 32'h0);
    step(3'b111, 32'h200, 32'h204,  32'h208, 0, 0, 0, 5, 0, 32'h100, 32'h108, 32'h200);
    step(3'b001, 32'h20C, 32'hEEE0, 32'hEEE4, 0, 0, 0, 6, 1, 32'h100, 32'h108, 32'h200);
    step(3'b111, 32'h300, 32'h304,  32'h308, 0, 0, 0, 6, 1, 32'h100, 32'h108, 32'h200);
    step(3'b000, 32'h0,   32'h0,    32'h0,   0, 0, 1, 5, 0, 32'h108, 32'h200, 32'h204);
    step(3'b000, 32'h0,   32'h0,    32'h0,   0, 0, 2, 3, 0, 32'h204, 32'h208, 32'h20C);
    step(3'b011, 32'h400, 32'h404,  32'h0,   0, 0, 0, 5, 0, 32'h204, 32'h208, 32'h20C);
    step(3'b111, 32'h500, 32'h504,  32'h508, 0, 0, 2, 6, 1, 32'h20C, 32'h400, 32'h404);
    step(3'b000, 32'h0,   32'h0,    32'h0,   0, 0, 2, 4, 0, 32'h404, 32'h500, 32'h504);
    step(3'b111, 32'h600, 32'h604,  32'h608, 0, 1, 2, 0, 0, 32'h0,   32'h0,   32'h0);
    step(3'b111, 32'h700, 32'h704,  32'h708, 0, 0, 0, 3, 0, 32'h700, 32'h704, 32'h708);
    step(3'b010, 32'h0,   32'h800,  32'h0,   0, 0, 3, 1, 0, 32'h800, 32'h0,   32'h0);
    step(3'b001, 32'h900, 32'h0,    32'h0,   0, 0, 0, 2, 0, 32'h800, 32'h900, 32'h0);
    step(3'b000, 32'h0,   32'h0,    32'h0,   0, 0, 3, 0, 0, 32'h0,   32'h0,   32'h0);
    step(3'b111, 32'hA00, 32'hA04,  32'hA08, 0, 0, 0, 3, 0, 32'hA00, 32'hA04, 32'hA08);
    step(3'b111, 32'hB00, 32'hB04,  32'hB08, 1, 0, 1, 2, 0, 32'hA04, 32'hA08, 32'h0);

    // Asynchronous reset asserted between edges.
    #3;
    in_valid = '0; deq_num = '0; IF_pinch_off = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst count", 32'(count), 32'd0);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst full", 32'(IF_FIFO_full), 32'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("midrst pc[%0d]", i), out_pc[32*i +: 32], 32'd0);
    @(negedge clk);
    rst = 1'b1;

    step(3'b111, 32'hC00, 32'hC04,  32'hC08, 0, 0, 0, 3, 0, 32'hC00, 32'hC04, 32'hC08);

    @(negedge clk);
    in_valid = '0; deq_num = '0;
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d req=0 pending transactions", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fifo_multi.md
# if_fifo_multi

Parametrised multi-lane instruction queue between the fetch stage and decode. Each cycle it accepts up to LANES fetched instructions under a per-lane valid mask and packs the valid lanes contiguously in program order. It presents the oldest LANES entries to decode, and decode may consume any number of them from 0 to LANES. It supports flush, fetch pinch-off and a configurable depth, and exports occupancy for fetch throttling.

## Interface
Parameters:
- LANES, 3, instructions per fetch group and per decode group (>=1).
- DEPTH, 8, queue entries, one instruction each; power of two, >= LANES.
- PHT_W, 10, width of the PHT index field.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- IF_pinch_off  in  1  suppresses enqueue this cycle.
- flush_IF_FIFO  in  1  empties the queue at the next edge.
- in_valid  in  LANES  per-lane valid mask of the fetch group.
- in_pc, in_inst, in_pc_unsel  in  LANES*32 each  lane i occupies bits [32i+31:32i].
- in_predict_valid, in_predict  in  LANES each  per-lane branch prediction flags.
- in_pht_idx  in  LANES*PHT_W  per-lane PHT index.
- deq_num  in  $clog2(LANES+1)  number of head entries consumed by decode this cycle.
- out_valid  out  LANES  thermometer mask; bit i set when entry head+i exists.
- out_pc, out_inst, out_pc_unsel, out_predict_valid, out_predict, out_pht_idx  out  as the matching inputs  fields of entries head..head+LANES-1; lane 0 is the oldest.
- count  out  $clog2(DEPTH+1)  current occupancy.
- IF_FIFO_full  out  1  high when DEPTH-count < LANES.

## Operation
- Storage: circular buffer of DEPTH entries. Fields per entry: pc, inst, pc_unsel, predict_valid, predict, pht_idx. head_ptr and tail_ptr are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- Accept: accept = |in_valid & !IF_pinch_off & !IF_FIFO_full & !flush_IF_FIFO. A group is accepted whole or not at all; there is no partial acceptance.
- Compaction: on accept, the k-th set bit of in_valid (counting from lane 0) is written to entry tail_ptr+k. After the write, tail_ptr advances by popcount(in_valid).
- Dequeue: deq_eff = min(deq_num, count). Values larger than count are clamped, not an error. head_ptr advances by deq_eff.
- Next occupancy: count_next = count + (accept ? popcount(in_valid) : 0) - deq_eff.
- Full is evaluated on the pre-edge count. A simultaneous dequeue does not free space for the same-cycle enqueue.
- Outputs: out_valid[i] = (i < count). Out fields are read combinationally from registered storage at head_ptr+i, modulo DEPTH. Fields of lanes with out_valid low are don't-care.
- Flush has priority over everything else. At the next edge head_ptr, tail_ptr and count become 0, and the same-cycle enqueue and dequeue are discarded.
- Pinch-off only blocks enqueue. Dequeue proceeds normally while it is high.

## Timing
- Reset (rst low, asynchronous): head_ptr=0, tail_ptr=0, count=0, storage cleared to 0.
  - Resulting outputs: out_valid=0, IF_FIFO_full=0, count=0, all out fields 0.
  - Reset takes effect mid-operation without waiting for a clock edge.
- Enqueue-to-output latency: 1 cycle. There is no bypass; data enqueued at edge N is visible after edge N.
- Dequeue: the consumed entries leave out_valid after the same edge. The remaining entries shift to lane 0 at that edge.
- IF_FIFO_full and count are registered-derived and change only at edges or on reset.
- Wrap-around is transparent: output order is preserved across the DEPTH-1 to 0 boundary.

## Test plan
- Reset, then in_valid=3'b111 with in_pc=0x1C000000/04/08 -> the next cycle shows out_valid=3'b111, out_pc lanes 0x1C000000/04/08, count=3.
- From empty, in_valid=3'b101 with lane0 pc=0x100 and lane2 pc=0x108 -> out_valid=3'b011, out_pc[0]=0x100, out_pc[1]=0x108, count=2. Check that predict, pht_idx and pc_unsel follow their lanes.
- Fill to count=6 -> IF_FIFO_full=1, and a further 3'b111 group is ignored (count stays 6). Then deq_num=1 -> count=5, full=0 the next cycle.
- Wrap: at count=5 with head_ptr=6, enqueue 3 instructions and set deq_num=2 -> count=6, and out_pc order is continuous across entry 7 to entry 0.
- Assert flush_IF_FIFO together with enqueue 3'b111 and deq_num=2 at count=4 -> count=0, out_valid=0 and pointers at 0 the next cycle. A following enqueue lands at entry 0.
- Cover these mixed cases:
  - deq_num=3 at count=2 -> count=0, no underflow.
  - IF_pinch_off=1 with enqueue plus deq_num=1 -> count decreases by 1 only.
  - rst low between edges -> all outputs 0 immediately.
